codec_cfg_ctrl: RTL and testbench
=================================

// Module: codec_cfg_ctrl
// PURPOSE
//  Sequencer that drives the 24-bit I2C sender (start / data / finished) to configure the WM8731 codec.
//  After reset it waits a power-up delay, then issues a fixed 7-word init table, one word at a time.
//  After init it serves single-register runtime updates (e.g. headphone volume) from a valid/ready port.
//  It also accepts a re-init request. Sits between top-level control and the I2C sender; sole owner of the sender.
// PARAMETERS
//  STARTUP_CYCLES  16     i_clk cycles from reset release to first command (codec power-up)
//  GAP_CYCLES      4      idle cycles after each completed transfer before the next issue/ready
//  DEV_ADDR        8'h34  I2C write address placed in word bits [23:16]
// PORTS
//  i_clk           in   1   clock
//  i_rst           in   1   asynchronous, active-low reset
//  i_reinit        in   1   level; sampled in S_IDLE only: replay init table
//  i_upd_valid     in   1   runtime update request
//  i_upd_reg       in   7   codec register address
//  i_upd_data      in   9   codec register data
//  o_upd_ready     out  1   update accepted when i_upd_valid && o_upd_ready
//  o_i2c_start     out  1   one-cycle start pulse to sender
//  o_i2c_data      out  24  word to sender: {DEV_ADDR, reg[6:0], data[8:0]}
//  i_i2c_finished  in   1   sender finished level (low while busy, high when done)
//  o_init_done     out  1   high once init table completed; low during init/re-init
//  o_busy          out  1   high in every state except S_IDLE
// BEHAVIOUR
//  Reset values: o_i2c_start=0, o_i2c_data=0, o_init_done=0, o_busy=1, o_upd_ready=0, state=S_STARTUP, idx=0, cnt=0.
//  Init table, idx 0..6, fixed in this order:
//   24'h341E00 (R15 reset), 24'h340815 (R4), 24'h340A00 (R5), 24'h340C00 (R6),
//   24'h340E42 (R7), 24'h341019 (R8), 24'h341201 (R9 active).
//  Register fin_q <= i_i2c_finished (reset 0). done_evt = i_i2c_finished && !fin_q (rising edge only).
//  States:
//   S_STARTUP: count cnt to STARTUP_CYCLES-1, then -> S_ISSUE with idx=0, mode=INIT.
//   S_ISSUE: o_i2c_start=1 for exactly this cycle.
//    o_i2c_data = table[idx] (INIT) or the latched update word (UPD). Next state S_BUSY.
//   S_BUSY: o_i2c_data held. Wait for done_evt; no timeout; start never reasserted here.
//    On done_evt -> S_GAP, cnt=0.
//   S_GAP: count GAP_CYCLES cycles. Then:
//    INIT && idx<6 -> idx++, S_ISSUE.
//    INIT && idx==6 -> o_init_done<=1, S_IDLE.
//    UPD -> S_IDLE.
//   S_IDLE: o_busy=0. o_upd_ready = (state==S_IDLE) && !i_reinit (combinational).
//    i_reinit=1 -> o_init_done<=0, idx=0, mode=INIT, S_ISSUE. Reinit has priority over a same-cycle update.
//    else i_upd_valid -> latch {DEV_ADDR,i_upd_reg,i_upd_data}, mode=UPD, S_ISSUE.
//  Issue latency: update accepted in cycle N -> o_i2c_start high in cycle N+1.
//  Updates are never accepted outside S_IDLE. The requester holds valid; no queueing.
//  Reset mid-transfer: all state to reset values asynchronously. Sequence restarts at idx 0 after STARTUP_CYCLES.
//   The sender shares i_rst, so no partial transfer is resumed.
//  Counters are sized to hold max(STARTUP_CYCLES, GAP_CYCLES). idx is 3 bits and never wraps past 6.
// TESTING
//  T1 Release reset, sender model finishes 40 cycles after each start ->
//     first start at STARTUP_CYCLES; 7 pulses carry 341E00,340815,340A00,340C00,340E42,341019,341201 in order;
//     consecutive pulses are >= GAP_CYCLES+1 cycles past each finished rise; o_init_done=1 after the last gap.
//  T2 In IDLE, valid, reg=7'h02, data=9'h079 -> ready=1 that cycle; start next cycle with 24'h340479;
//     o_busy=1 until the gap ends; ready=0 throughout.
//  T3 valid held high during init -> ready=0 and no update word is issued before o_init_done.
//     Update issued exactly once after init.
//  T4 In IDLE, i_reinit and valid in the same cycle -> ready=0, o_init_done falls, the 7-word table replays;
//     update issued after replay.
//  T5 Assert i_rst during BUSY of idx 3 -> all outputs at reset values immediately;
//     after release, first start carries 341E00.
//  T6 Finished held high (no new edge) after a start -> stays in S_BUSY, no further o_i2c_start;
//     a later 0->1 edge resumes the sequence.

Source files
------------

// File: rtl/codec_cfg_ctrl.sv
// codec_cfg_ctrl
// Configuration sequencer for the WM8731 audio codec. It is the only block
// that drives the 24-bit I2C sender, which has start, data and finished
// signals.
// After reset it waits for the codec to power up. It then sends a fixed
// 7-word init table, one word per transfer. Once init is complete it sends
// single-register runtime updates taken from a valid/ready port. A re-init
// request replays the whole init table.
module codec_cfg_ctrl #(
    parameter int unsigned STARTUP_CYCLES = 16,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter logic [7:0]  DEV_ADDR       = 8'h34
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_reinit,
    input  logic        i_upd_valid,
    input  logic [6:0]  i_upd_reg,
    input  logic [8:0]  i_upd_data,
    output logic        o_upd_ready,
    output logic        o_i2c_start,
    output logic [23:0] o_i2c_data,
    input  logic        i_i2c_finished,
    output logic        o_init_done,
    output logic        o_busy
);

    // One counter is shared by the power-up wait and the inter-transfer gap.
    // It is sized for the longer of the two.
    localparam int unsigned CNT_MAX = (STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST     = 3'd6;

    typedef enum logic [2:0] {
        S_STARTUP,
        S_ISSUE,
        S_BUSY,
        S_GAP,
        S_IDLE
    } state_t;

    typedef enum logic {
        MODE_INIT,
        MODE_UPD
    } mode_t;

    state_t           state_reg;
    mode_t            mode_reg;
    logic [2:0]       idx_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             fin_q;
    logic             done_evt;

    // Init table contents. The device address goes in the top byte and the
    // rest is {reg[6:0], data[8:0]}. The order matters: first the codec reset
    // (R15), then R4..R8, and last the active bit (R9).
    function automatic logic [23:0] init_word(input logic [2:0] idx);
        logic [15:0] payload;
        case (idx)
            3'd0:    payload = 16'h1E00;   // R15: reset
            3'd1:    payload = 16'h0815;   // R4: analogue path
            3'd2:    payload = 16'h0A00;   // R5: digital path
            3'd3:    payload = 16'h0C00;   // R6: power down control
            3'd4:    payload = 16'h0E42;   // R7: digital interface format
            3'd5:    payload = 16'h1019;   // R8: sampling control
            3'd6:    payload = 16'h1201;   // R9: active
            default: payload = 16'h1E00;   // unreachable: idx stops at 6
        endcase
        return {DEV_ADDR, payload};
    endfunction

    // The sender reports completion as a level, so only a 0->1 edge counts.
    // A finished line that stays high from the last transfer is ignored.
    assign done_evt = i_i2c_finished && !fin_q;

    // Updates are accepted only in idle, and never while a re-init is requested.
    assign o_upd_ready = (state_reg == S_IDLE) && !i_reinit;

    // Sequencer FSM. Start, data, init_done and busy are all registered. They
    // are loaded on the transition into the state that they describe.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg   <= S_STARTUP;
            mode_reg    <= MODE_INIT;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            fin_q       <= 1'b0;
            o_i2c_start <= 1'b0;
            o_i2c_data  <= '0;
            o_init_done <= 1'b0;
            o_busy      <= 1'b1;
        end else begin
            fin_q       <= i_i2c_finished;
            o_i2c_start <= 1'b0;

            case (state_reg)
                S_STARTUP: begin
                    // Codec power-up delay, then the first table word.
                    if (cnt_reg == STARTUP_LAST) begin
                        cnt_reg     <= '0;
                        idx_reg     <= '0;
                        mode_reg    <= MODE_INIT;
                        o_i2c_start <= 1'b1;
                        o_i2c_data  <= init_word(3'd0);
                        state_reg   <= S_ISSUE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_ISSUE: begin
                    // The start pulse lasts only this cycle. The data word is held.
                    state_reg <= S_BUSY;
                end

                S_BUSY: begin
                    // No timeout here: the sender shares our reset, so a hung
                    // transfer is cleared by reset and not by this block.
                    if (done_evt) begin
                        cnt_reg   <= '0;
                        state_reg <= S_GAP;
                    end
                end

                S_GAP: begin
                    // Fixed idle time after every transfer before the next one.
                    if (cnt_reg == GAP_LAST) begin
                        cnt_reg <= '0;
                        if (mode_reg == MODE_UPD) begin
                            o_busy    <= 1'b0;
                            state_reg <= S_IDLE;
                        end else if (idx_reg < IDX_LAST) begin
                            idx_reg     <= idx_reg + 3'd1;
                            o_i2c_start <= 1'b1;
                            o_i2c_data  <= init_word(idx_reg + 3'd1);
                            state_reg   <= S_ISSUE;
                        end else begin
                            o_init_done <= 1'b1;
                            o_busy      <= 1'b0;
                            state_reg   <= S_IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_IDLE: begin
                    // A re-init wins over an update offered in the same cycle.
                    // The update is still held by the requester and is taken
                    // after the replay.
                    if (i_reinit) begin
                        o_init_done <= 1'b0;
                        o_busy      <= 1'b1;
                        idx_reg     <= '0;
                        mode_reg    <= MODE_INIT;
                        o_i2c_start <= 1'b1;
                        o_i2c_data  <= init_word(3'd0);
                        state_reg   <= S_ISSUE;
                    end else if (i_upd_valid) begin
                        o_busy      <= 1'b1;
                        mode_reg    <= MODE_UPD;
                        o_i2c_start <= 1'b1;
                        o_i2c_data  <= {DEV_ADDR, i_upd_reg, i_upd_data};
                        state_reg   <= S_ISSUE;
                    end
                end

                default: begin
                    // Recovery from an illegal encoding: restart the whole sequence.
                    cnt_reg     <= '0;
                    idx_reg     <= '0;
                    mode_reg    <= MODE_INIT;
                    o_init_done <= 1'b0;
                    o_busy      <= 1'b1;
                    state_reg   <= S_STARTUP;
                end
            endcase
        end
    end

    // Start is only ever seen together with the issue state, and lasts one cycle.
    a_start_in_issue: assert property (@(posedge i_clk) disable iff (!i_rst)
        o_i2c_start |-> (state_reg == S_ISSUE));

    a_start_single: assert property (@(posedge i_clk) disable iff (!i_rst)
        o_i2c_start |=> !o_i2c_start);

    // The table index never goes beyond the last table entry.
    a_idx_range: assert property (@(posedge i_clk) disable iff (!i_rst)
        idx_reg <= IDX_LAST);

endmodule

// File: tb/tb_codec_cfg_ctrl.sv
// tb_codec_cfg_ctrl
// Directed bench for codec_cfg_ctrl.
// A sender model drops finished when it sees a start and raises it 40 cycles
// later. A monitor logs every start pulse: the word it carries and its distance
// from the last rise of finished.
`timescale 1ns/1ps
module tb_codec_cfg_ctrl;

    localparam int STARTUP  = 16;
    localparam int GAP      = 4;
    localparam int SEND_LAT = 40;

    logic        clk;
    logic        rst_n;
    logic        reinit;
    logic        upd_valid;
    logic [6:0]  upd_reg;
    logic [8:0]  upd_data;
    logic        upd_ready;
    logic        i2c_start;
    logic [23:0] i2c_data;
    logic        fin;
    logic        init_done;
    logic        busy;

    logic        model_en;
    logic        model_fin;
    logic        man_fin;
    int          model_cnt;

    int          tests_run;
    int          tests_failed;

    int          cyc;
    logic [23:0] word_q[$];
    int          dist_q[$];

    codec_cfg_ctrl #(
        .STARTUP_CYCLES(STARTUP),
        .GAP_CYCLES    (GAP),
        .DEV_ADDR      (8'h34)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_reinit      (reinit),
        .i_upd_valid   (upd_valid),
        .i_upd_reg     (upd_reg),
        .i_upd_data    (upd_data),
        .o_upd_ready   (upd_ready),
        .o_i2c_start   (i2c_start),
        .o_i2c_data    (i2c_data),
        .i_i2c_finished(fin),
        .o_init_done   (init_done),
        .o_busy        (busy)
    );

    assign fin = model_en ? model_fin : man_fin;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected init table, written out by hand.
    function automatic logic [23:0] exp_word(input int k);
        case (k)
            0:       return 24'h341E00;
            1:       return 24'h340815;
            2:       return 24'h340A00;
            3:       return 24'h340C00;
            4:       return 24'h340E42;
            5:       return 24'h341019;
            6:       return 24'h341201;
            default: return 24'h000000;
        endcase
    endfunction

    // Sender model. It acts on falling edges and shares reset with the DUT.
    initial begin
        model_fin = 1'b0;
        model_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !model_en) begin
                model_cnt = 0;
                if (!rst_n) model_fin = 1'b0;
            end else if (i2c_start) begin
                model_fin = 1'b0;
                model_cnt = SEND_LAT;
            end else if (model_cnt > 0) begin
                model_cnt = model_cnt - 1;
                if (model_cnt == 0) model_fin = 1'b1;
            end
        end
    end

    // Monitor: prints one line per transfer issued.
    initial begin
        logic prev_fin;
        int   last_rise;
        bit   rise_pend;
        prev_fin  = 1'b0;
        last_rise = 0;
        rise_pend = 1'b0;
        cyc       = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc = cyc + 1;
            if (fin === 1'b1 && prev_fin !== 1'b1) begin
                last_rise = cyc;
                rise_pend = 1'b1;
            end
            prev_fin = fin;
            if (i2c_start === 1'b1) begin
                word_q.push_back(i2c_data);
                dist_q.push_back(rise_pend ? (cyc - last_rise) : -1);
                rise_pend = 1'b0;
                $display("[TB] xfer %0d cyc=%0d word=%06h init_done=%0b", word_q.size(), cyc, i2c_data, init_done);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (i2c_start !== 1'b0) begin tests_failed++; $display("FAIL reset_start: got %0b want 0", i2c_start); end
        tests_run++;
        if (i2c_data !== 24'h000000) begin tests_failed++; $display("FAIL reset_data: got %06h want 000000", i2c_data); end
        tests_run++;
        if (init_done !== 1'b0) begin tests_failed++; $display("FAIL reset_init_done: got %0b want 0", init_done); end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy: got %0b want 1", busy); end
        tests_run++;
        if (upd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %0b want 0", upd_ready); end
    endtask

    task automatic test_init_sequence();
        int n;
        int base;
        logic [23:0] got;
        base = word_q.size();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && i2c_start !== 1'b1; i++) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== STARTUP) begin tests_failed++; $display("FAIL init_first_start: got %0d cycles want %0d", n, STARTUP); end
        tests_run++;
        if (i2c_data !== 24'h341E00) begin tests_failed++; $display("FAIL init_first_word: got %06h want 341E00", i2c_data); end
        for (int i = 0; i < 2000 && init_done !== 1'b1; i++) tick();
        tests_run++;
        if (init_done !== 1'b1) begin tests_failed++; $display("FAIL init_done: got %0b want 1", init_done); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL init_idle_busy: got %0b want 0", busy); end
        tests_run++;
        if (word_q.size() - base !== 7) begin tests_failed++; $display("FAIL init_count: got %0d want 7", word_q.size() - base); end
        for (int k = 0; k < 7; k++) begin
            got = (base + k < word_q.size()) ? word_q[base + k] : 24'hxxxxxx;
            tests_run++;
            if (got !== exp_word(k)) begin tests_failed++; $display("FAIL init_word%0d: got %06h want %06h", k, got, exp_word(k)); end
        end
        for (int k = 1; k < 7; k++) begin
            n = (base + k < dist_q.size()) ? dist_q[base + k] : -99;
            tests_run++;
            if (n !== GAP + 1) begin tests_failed++; $display("FAIL init_gap%0d: got %0d want %0d", k, n, GAP + 1); end
        end
    endtask

    task automatic test_update();
        int nb;
        int rv;
        @(negedge clk);
        upd_reg   = 7'h02;
        upd_data  = 9'h079;
        upd_valid = 1'b1;
        #1;
        tests_run++;
        if (upd_ready !== 1'b1) begin tests_failed++; $display("FAIL upd_ready_idle: got %0b want 1", upd_ready); end
        tick();
        upd_valid = 1'b0;
        tests_run++;
        if (i2c_start !== 1'b1) begin tests_failed++; $display("FAIL upd_start: got %0b want 1", i2c_start); end
        tests_run++;
        if (i2c_data !== 24'h340479) begin tests_failed++; $display("FAIL upd_word: got %06h want 340479", i2c_data); end
        nb = 0;
        rv = 0;
        for (int i = 0; i < 200 && busy === 1'b1; i++) begin
            nb++;
            if (upd_ready !== 1'b0) rv++;
            tick();
        end
        tests_run++;
        if (nb !== SEND_LAT + GAP + 1) begin tests_failed++; $display("FAIL upd_busy_len: got %0d want %0d", nb, SEND_LAT + GAP + 1); end
        tests_run++;
        if (rv !== 0) begin tests_failed++; $display("FAIL upd_ready_busy: got %0d cycles want 0", rv); end
    endtask

    task automatic test_reinit_priority();
        int base;
        int rv;
        logic [23:0] got;
        base = word_q.size();
        @(negedge clk);
        upd_reg   = 7'h04;
        upd_data  = 9'h0AB;
        upd_valid = 1'b1;
        reinit    = 1'b1;
        #1;
        tests_run++;
        if (upd_ready !== 1'b0) begin tests_failed++; $display("FAIL reinit_ready: got %0b want 0", upd_ready); end
        tick();
        reinit = 1'b0;
        tests_run++;
        if (i2c_data !== 24'h341E00 || i2c_start !== 1'b1) begin tests_failed++; $display("FAIL reinit_first: got start=%0b word=%06h want 1/341E00", i2c_start, i2c_data); end
        tests_run++;
        if (init_done !== 1'b0) begin tests_failed++; $display("FAIL reinit_done_fall: got %0b want 0", init_done); end
        rv = 0;
        for (int i = 0; i < 2000 && init_done !== 1'b1; i++) begin
            if (upd_ready !== 1'b0) rv++;
            tick();
        end
        tests_run++;
        if (rv !== 0) begin tests_failed++; $display("FAIL reinit_ready_busy: got %0d cycles want 0", rv); end
        for (int i = 0; i < 20 && i2c_start !== 1'b1; i++) tick();
        upd_valid = 1'b0;
        tests_run++;
        if (i2c_data !== 24'h3408AB || i2c_start !== 1'b1) begin tests_failed++; $display("FAIL reinit_upd: got start=%0b word=%06h want 1/3408AB", i2c_start, i2c_data); end
        for (int i = 0; i < 200 && busy === 1'b1; i++) tick();
        tests_run++;
        if (word_q.size() - base !== 8) begin tests_failed++; $display("FAIL reinit_count: got %0d want 8", word_q.size() - base); end
        for (int k = 0; k < 7; k++) begin
            got = (base + k < word_q.size()) ? word_q[base + k] : 24'hxxxxxx;
            tests_run++;
            if (got !== exp_word(k)) begin tests_failed++; $display("FAIL reinit_word%0d: got %06h want %06h", k, got, exp_word(k)); end
        end
    endtask

    task automatic test_valid_during_init();
        int base;
        int rv;
        logic [23:0] got;
        rst_n     = 1'b0;
        upd_reg   = 7'h03;
        upd_data  = 9'h079;
        upd_valid = 1'b1;
        repeat (2) tick();
        base = word_q.size();
        @(negedge clk);
        rst_n = 1'b1;
        rv = 0;
        for (int i = 0; i < 2000 && init_done !== 1'b1; i++) begin
            if (upd_ready !== 1'b0) rv++;
            tick();
        end
        tests_run++;
        if (rv !== 0) begin tests_failed++; $display("FAIL vinit_ready: got %0d cycles want 0", rv); end
        tests_run++;
        if (word_q.size() - base !== 7) begin tests_failed++; $display("FAIL vinit_count_pre: got %0d want 7", word_q.size() - base); end
        for (int k = 0; k < 7; k++) begin
            got = (base + k < word_q.size()) ? word_q[base + k] : 24'hxxxxxx;
            tests_run++;
            if (got !== exp_word(k)) begin tests_failed++; $display("FAIL vinit_word%0d: got %06h want %06h", k, got, exp_word(k)); end
        end
        for (int i = 0; i < 20 && i2c_start !== 1'b1; i++) tick();
        upd_valid = 1'b0;
        tests_run++;
        if (i2c_data !== 24'h340679 || i2c_start !== 1'b1) begin tests_failed++; $display("FAIL vinit_upd: got start=%0b word=%06h want 1/340679", i2c_start, i2c_data); end
        for (int i = 0; i < 200 && busy === 1'b1; i++) tick();
        repeat (20) tick();
        tests_run++;
        if (word_q.size() - base !== 8) begin tests_failed++; $display("FAIL vinit_once: got %0d xfers want 8", word_q.size() - base); end
    endtask

    task automatic test_reset_mid_transfer();
        int base;
        int n;
        base = word_q.size();
        @(negedge clk);
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        for (int i = 0; i < 500 && word_q.size() < base + 4; i++) tick();
        repeat (10) tick();
        tests_run++;
        if (busy !== 1'b1 || i2c_data !== 24'h340C00) begin tests_failed++; $display("FAIL rst_mid_setup: got busy=%0b word=%06h want 1/340C00", busy, i2c_data); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (i2c_data !== 24'h000000) begin tests_failed++; $display("FAIL rst_mid_data: got %06h want 000000", i2c_data); end
        tests_run++;
        if (busy !== 1'b1 || init_done !== 1'b0 || upd_ready !== 1'b0 || i2c_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_ctrl: got busy=%0b done=%0b ready=%0b start=%0b want 1/0/0/0", busy, init_done, upd_ready, i2c_start);
        end
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && i2c_start !== 1'b1; i++) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== STARTUP) begin tests_failed++; $display("FAIL rst_mid_restart: got %0d cycles want %0d", n, STARTUP); end
        tests_run++;
        if (i2c_data !== 24'h341E00) begin tests_failed++; $display("FAIL rst_mid_word: got %06h want 341E00", i2c_data); end
        for (int i = 0; i < 2000 && init_done !== 1'b1; i++) tick();
        tests_run++;
        if (init_done !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_done: got %0b want 1", init_done); end
    endtask

    task automatic test_finished_stuck();
        int ns;
        int nb;
        int d;
        @(negedge clk);
        man_fin  = 1'b1;
        model_en = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        tests_run++;
        if (i2c_start !== 1'b1 || i2c_data !== 24'h341E00) begin tests_failed++; $display("FAIL stuck_first: got start=%0b word=%06h want 1/341E00", i2c_start, i2c_data); end
        ns = 0;
        nb = 0;
        repeat (60) begin
            tick();
            if (i2c_start !== 1'b0) ns++;
            if (busy !== 1'b1) nb++;
        end
        tests_run++;
        if (ns !== 0) begin tests_failed++; $display("FAIL stuck_no_start: got %0d starts want 0", ns); end
        tests_run++;
        if (nb !== 0) begin tests_failed++; $display("FAIL stuck_busy: got %0d idle cycles want 0", nb); end
        for (int w = 1; w < 7; w++) begin
            @(negedge clk);
            man_fin = 1'b0;
            repeat (2) tick();
            @(negedge clk);
            man_fin = 1'b1;
            for (int i = 0; i < 20 && i2c_start !== 1'b1; i++) tick();
            tests_run++;
            if (i2c_start !== 1'b1 || i2c_data !== exp_word(w)) begin
                tests_failed++;
                $display("FAIL stuck_resume%0d: got start=%0b word=%06h want 1/%06h", w, i2c_start, i2c_data, exp_word(w));
            end
        end
        tick();
        d = (dist_q.size() > 0) ? dist_q[dist_q.size() - 1] : -99;
        tests_run++;
        if (d !== GAP + 1) begin tests_failed++; $display("FAIL stuck_gap: got %0d want %0d", d, GAP + 1); end
        @(negedge clk);
        man_fin = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        man_fin = 1'b1;
        for (int i = 0; i < 20 && init_done !== 1'b1; i++) tick();
        tests_run++;
        if (init_done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL stuck_done: got done=%0b busy=%0b want 1/0", init_done, busy); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        reinit       = 1'b0;
        upd_valid    = 1'b0;
        upd_reg      = '0;
        upd_data     = '0;
        model_en     = 1'b1;
        man_fin      = 1'b0;

        test_reset();
        test_init_sequence();
        test_update();
        test_reinit_priority();
        test_valid_during_init();
        test_reset_mid_transfer();
        test_finished_stuck();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
